// File: rtl/spi_slave_pkg.sv
// Shared constants for the oversampled SPI slave: FSM encoding, default word width, mode helpers.
package spi_slave_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    // CPHA value that places the sampling edge on the trailing sclk transition
    localparam logic CPHA_SAMPLE_TRAILING = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall pulses taken against a third flop.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync   = s2;
    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

endmodule

// File: rtl/spi_slave_core.sv
// Single-lane SPI slave oversampled on pclk: one-entry tx buffer, word-parallel rx/tx client side.
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter bit                    CPOL         = 1'b0,
    parameter bit                    CPHA         = 1'b0,
    parameter bit                    MSB_FIRST    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TX_BIT = MSB_FIRST ? DATA_WIDTH - 1 : 0;

    logic sclk_lvl_unused, sclk_rise_c, sclk_fall_c;
    logic cs_lvl_unused, cs_rise_c, cs_fall_c;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk(pclk), .rst_n(areset), .din(sclk),
        .sync(sclk_lvl_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(pclk), .rst_n(areset), .din(cs_n),
        .sync(cs_lvl_unused), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(pclk), .rst_n(areset), .din(mosi),
        .sync(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    // Leading edge leaves the idle level; CPHA picks which edge samples
    logic lead_c, trail_c, sample_c, shift_c;
    assign lead_c   = CPOL ? sclk_fall_c : sclk_rise_c;
    assign trail_c  = CPOL ? sclk_rise_c : sclk_fall_c;
    assign sample_c = (CPHA == CPHA_SAMPLE_TRAILING) ? trail_c : lead_c;
    assign shift_c  = (CPHA == CPHA_SAMPLE_TRAILING) ? lead_c : trail_c;

    logic [0:0]            state_q, state_n;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_n;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_n;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_n;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_n;
    logic                  tx_ready_q, tx_ready_n;
    logic                  rx_valid_q, rx_valid_n;
    logic                  tx_underrun_q, tx_underrun_n;
    logic                  frame_abort_q, frame_abort_n;
    logic                  miso_q, miso_n;
    logic                  load;

    always_ff @(posedge pclk) begin
        if (!areset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            rx_data_q     <= '0;
            tx_ready_q    <= 1'b1;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_n;
            bit_cnt_q     <= bit_cnt_n;
            rx_shift_q    <= rx_shift_n;
            tx_shift_q    <= tx_shift_n;
            tx_buf_q      <= tx_buf_n;
            rx_data_q     <= rx_data_n;
            tx_ready_q    <= tx_ready_n;
            rx_valid_q    <= rx_valid_n;
            tx_underrun_q <= tx_underrun_n;
            frame_abort_q <= frame_abort_n;
            miso_q        <= miso_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        bit_cnt_n     = bit_cnt_q;
        rx_shift_n    = rx_shift_q;
        tx_shift_n    = tx_shift_q;
        tx_buf_n      = tx_buf_q;
        rx_data_n     = rx_data_q;
        tx_ready_n    = tx_ready_q;
        rx_valid_n    = 1'b0;
        tx_underrun_n = 1'b0;
        frame_abort_n = 1'b0;
        load          = 1'b0;
        miso_n        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_n   = ACTIVE;
                    bit_cnt_n = '0;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                // cs_n release takes priority over a coincident sample edge
                if (cs_rise_c) begin
                    state_n       = IDLE;
                    frame_abort_n = (bit_cnt_q != '0);
                    bit_cnt_n     = '0;
                end else if (sample_c) begin
                    rx_shift_n = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                           : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        rx_data_n  = rx_shift_n;
                        rx_valid_n = 1'b1;
                        bit_cnt_n  = '0;
                        load       = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_c && (bit_cnt_q != '0)) begin
                    tx_shift_n = MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            if (tx_ready_q) begin
                tx_shift_n    = TX_IDLE_WORD;
                tx_underrun_n = 1'b1;
            end else begin
                tx_shift_n = tx_buf_q;
                tx_ready_n = 1'b1;
            end
        end

        // A write landing in the same cycle as a consume still fills the buffer
        if (tx_valid && tx_ready_q) begin
            tx_buf_n   = tx_data;
            tx_ready_n = 1'b0;
        end

        if (state_n == ACTIVE) begin
            miso_n = tx_shift_n[TX_BIT];
        end
    end

    logic busy_q;
    always_ff @(posedge pclk) begin
        if (!areset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_n == ACTIVE);
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = busy_q;
    assign busy        = busy_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Randomized bench: two slaves (mode 0 MSB-first, mode 3 LSB-first) driven by a behavioural SPI master.
module tb_spi_slave_core;

    logic       clk = 1'b0;
    logic       areset;
    logic       sclk[2], cs_n[2], mosi[2], tx_valid[2];
    logic [7:0] tx_data[2];
    logic       miso[2], miso_oe[2], tx_ready[2], rx_valid[2];
    logic       tx_underrun[2], frame_abort[2], busy[2];
    logic [7:0] rx_data[2];

    int n_checks = 0;
    int n_pass   = 0;

    int         n_rxv[2], n_und[2], n_abort[2];
    logic [7:0] rx_got[2][64];

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .pclk(clk), .areset(areset), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0]), .busy(busy[0])
    );

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut1 (
        .pclk(clk), .areset(areset), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .tx_underrun(tx_underrun[1]), .frame_abort(frame_abort[1]), .busy(busy[1])
    );

    initial begin
        for (int d = 0; d < 2; d++) begin
            n_rxv[d] = 0; n_und[d] = 0; n_abort[d] = 0;
        end
    end

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rx_valid[d]) begin
                rx_got[d][n_rxv[d] % 64] = rx_data[d];
                n_rxv[d] = n_rxv[d] + 1;
            end
            if (tx_underrun[d]) n_und[d] = n_und[d] + 1;
            if (frame_abort[d]) n_abort[d] = n_abort[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_rx_data", 32'(rx_data[d]), 32'h0);
        check("rst_tx_ready", 32'(tx_ready[d]), 32'h1);
        check("rst_busy", 32'(busy[d]), 32'h0);
        check("rst_miso_oe", 32'(miso_oe[d]), 32'h0);
        check("rst_miso", 32'(miso[d]), 32'h0);
        check("rst_rx_valid", 32'(rx_valid[d]), 32'h0);
    endtask

    task automatic push_tx(input int d, input logic [7:0] v);
        int k = 0;
        @(negedge clk);
        while (!tx_ready[d] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready[d]) check("tx_ready_wait", 32'(tx_ready[d]), 32'h1);
        tx_data[d]  = v;
        tx_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[d] = 1'b0;
    endtask

    // One chip-select frame of nbits; word k of the slave's reply is t[k] while supplied, else 0xFF
    task automatic run_frame(input int d, input int nbits, input int ntx,
                             input logic [7:0] w[4], input logic [7:0] t[4], input bit rst_mid);
        int         h     = int'($urandom_range(4, 7));
        bit         cpol  = (d == 1);
        bit         cpha  = (d == 1);
        bit         msb   = (d == 0);
        int         full  = nbits / 8;
        int         rx0   = n_rxv[d];
        int         und0  = n_und[d];
        int         ab0   = n_abort[d];
        logic [7:0] prev  = rx_data[d];
        logic [7:0] rd[4];
        int         consumes;
        for (int k = 0; k < 4; k++) rd[k] = 8'h00;

        if (ntx > 0) push_tx(d, t[0]);
        fork
            begin
                tick(1);
                cs_n[d] = 1'b0;
                if (!cpha) mosi[d] = w[0][msb ? 7 : 0];
                tick(h);
                check("busy_in_frame", 32'(busy[d]), 32'h1);
                check("miso_oe_in_frame", 32'(miso_oe[d]), 32'h1);
                for (int b = 0; b < nbits; b++) begin
                    int wi  = b / 8;
                    int pos = msb ? 7 - (b % 8) : (b % 8);
                    if (!cpha) rd[wi][pos] = miso[d];
                    sclk[d] = ~cpol;
                    if (cpha) mosi[d] = w[wi][pos];
                    tick(h);
                    if (cpha) rd[wi][pos] = miso[d];
                    sclk[d] = cpol;
                    if (!cpha && (b + 1 < nbits))
                        mosi[d] = w[(b + 1) / 8][msb ? 7 - ((b + 1) % 8) : ((b + 1) % 8)];
                    tick(h);
                end
            end
            begin
                for (int i = 1; i < ntx; i++) push_tx(d, t[i]);
            end
        join

        if (rst_mid) begin
            areset = 1'b0;
            tick(2);
            cs_n[d] = 1'b1;
            tick(2);
            check_reset_outputs(d);
            areset = 1'b1;
            tick(6);
            full     = 0;
            consumes = 1;
        end else begin
            cs_n[d] = 1'b1;
            tick(h + 4);
            consumes = full + 1;
            check("abort_count", 32'(n_abort[d] - ab0), 32'((nbits % 8) != 0));
            check("rx_data_hold", 32'(rx_data[d]), 32'(full > 0 ? w[full-1] : prev));
        end
        check("rx_valid_count", 32'(n_rxv[d] - rx0), 32'(full));
        check("underrun_count", 32'(n_und[d] - und0), 32'(consumes - ntx));
        check("busy_after", 32'(busy[d]), 32'h0);
        check("miso_oe_after", 32'(miso_oe[d]), 32'h0);
        for (int k = 0; k < full; k++) begin
            check("rx_word", 32'(rx_got[d][(rx0 + k) % 64]), 32'(w[k]));
            check("miso_word", 32'(rd[k]), 32'(k < ntx ? t[k] : 8'hFF));
        end
    endtask

    initial begin
        logic [7:0] w[4];
        logic [7:0] t[4];
        areset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sclk[d] = (d == 1); cs_n[d] = 1'b1; mosi[d] = 1'b0;
            tx_valid[d] = 1'b0; tx_data[d] = 8'h00;
        end
        tick(5);
        check_reset_outputs(0);
        check_reset_outputs(1);
        areset = 1'b1;
        tick(5);

        w = '{8'hA5, 8'h00, 8'h00, 8'h00}; t = '{8'h3C, 8'h00, 8'h00, 8'h00};
        run_frame(0, 8, 1, w, t, 1'b0);
        w = '{8'h12, 8'h34, 8'h00, 8'h00}; t = '{8'h55, 8'hAA, 8'h00, 8'h00};
        run_frame(0, 16, 2, w, t, 1'b0);
        w = '{8'hFF, 8'h00, 8'h00, 8'h00}; t = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(0, 5, 0, w, t, 1'b0);
        w = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(0, 8, 0, w, t, 1'b0);
        w = '{8'h81, 8'h00, 8'h00, 8'h00}; t = '{8'h0F, 8'h00, 8'h00, 8'h00};
        run_frame(1, 8, 1, w, t, 1'b0);
        w = '{8'hC3, 8'h00, 8'h00, 8'h00}; t = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(0, 3, 0, w, t, 1'b1);
        run_frame(0, 8, 0, w, t, 1'b0);

        for (int i = 0; i < 16; i++) begin
            int nw   = int'($urandom_range(1, 3));
            int part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            int ntx  = int'($urandom_range(0, nw + 1));
            for (int k = 0; k < 4; k++) begin
                w[k] = 8'($urandom);
                t[k] = 8'($urandom);
            end
            run_frame(i % 2, nw * 8 + part, ntx, w, t, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
